// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with level interrupt request
//
// Bus responder with three registers selected by Addr[3:2]:
//   0 CTRL   : bit0 EN, bits[2:1] MODE, bit3 IM (upper bits read 0)
//   1 PRESET : reload value, read/write
//   2 COUNT  : current count, read-only
//   3        : reads 0, writes ignored
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   Addr  - device word address, only Addr[3:2] decoded
//   WE    - write strobe (already qualified by the bridge)
//   Din   - write data
//   Dout  - combinational read data
//   IRQ   - level interrupt request (IM & irq_flag)
//
// Build option: TIMER_AUTORELOAD_EN enables MODE=1 auto-reload. Without it the
// MODE field is not stored and every expiry is one-shot.

`timescale 1ns/1ps

module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        ctrl_en;
  logic        ctrl_im;
  logic [1:0]  ctrl_mode;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        expire;
  logic        auto_reload;

  // Only Addr[3:2] selects a register; the rest of the address is the bridge's.
  logic        unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  assign wr_ctrl   = WE && (Addr[3:2] == 2'd0);
  assign wr_preset = WE && (Addr[3:2] == 2'd1);

  // Counting reaches its final step when COUNT is 1 or already 0 (PRESET=0).
  assign expire = (state == CNT) && ctrl_en && (count <= 32'd1);

`ifdef TIMER_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_mode <= 2'b00;
    end else if (wr_ctrl) begin
      ctrl_mode <= Din[2:1];
    end
  end

  // MODE 2 and 3 fall back to one-shot.
  assign auto_reload = (ctrl_mode == 2'd1);
`else
  logic unused_mode_din;
  assign unused_mode_din = ^Din[2:1];
  assign ctrl_mode       = 2'b00;
  assign auto_reload     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ctrl_en) state_next = LOAD;
      LOAD: state_next = CNT;
      CNT: begin
        if (!ctrl_en) begin
          state_next = IDLE;
        end else if (count <= 32'd1) begin
          state_next = INT;
        end
      end
      INT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register file and counter. A bus write to CTRL takes priority over the
  // one-shot EN clear on the INT->IDLE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en  <= 1'b0;
      ctrl_im  <= 1'b0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= Din[0];
        ctrl_im <= Din[3];
      end else if ((state == INT) && !auto_reload) begin
        ctrl_en <= 1'b0;
      end

      if (wr_preset) begin
        preset <= Din;
      end

      // PRESET is only sampled in LOAD, so a write during CNT waits for the
      // next reload.
      if (state == LOAD) begin
        count <= preset;
      end else if ((state == CNT) && ctrl_en) begin
        count <= (count > 32'd1) ? (count - 32'd1) : 32'd0;
      end

      // An expiry on the same edge as a register write still raises the flag,
      // so software that unmasks at that moment does not lose the event.
      if (expire) begin
        irq_flag <= 1'b1;
      end else if (wr_ctrl || wr_preset) begin
        irq_flag <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      end else if ((state == INT) && auto_reload) begin
        irq_flag <= 1'b0;
`endif
      end
    end
  end

  // Combinational read mux
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'd0:    Dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev

`timescale 1ns/1ps

module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_PRESET = 32'h4;
  localparam logic [31:0] A_COUNT  = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit HAS_AUTO = 1'b1;
`else
  localparam bit HAS_AUTO = 1'b0;
`endif

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Reference: state of the timer k edges after EN=1 is written from a
  // freshly reset timer with PRESET=n. The period is PRESET (min 1) counting
  // steps plus LOAD/INT/IDLE overhead; one-shot stops after the first expiry.
  function automatic void ref_point(input int k, input int n, input bit autom,
                                    output int cnt, output bit flag, output bit en);
    int eff;
    int per;
    int ph;
    eff  = (n < 1) ? 1 : n;
    per  = eff + 3;
    cnt  = 0;
    flag = 1'b0;
    en   = 1'b1;
    if (k >= 2) begin
      if (autom) begin
        ph   = (k - 2) % per;
        cnt  = (ph < eff) ? (n - ph) : 0;
        flag = (ph == eff);
      end else begin
        ph   = k - 2;
        cnt  = (ph < eff) ? (n - ph) : 0;
        flag = (ph >= eff);
        en   = (k < eff + 3);
      end
    end
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], d);
      n_cmp++;
      if (d !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read addr=%0h got=%h exp=0", addrs[i], d);
      end
    end
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq got=%b exp=0", IRQ);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int c;
    bit f;
    bit en;
    do_reset();
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 11; k++) begin
      tick();
      ref_point(k, 5, 1'b0, c, f, en);
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'(c)) begin
        n_err++;
        $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, d, c);
      end
      n_cmp++;
      if (IRQ !== f) begin
        n_err++;
        $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, IRQ, f);
      end
      rd(A_CTRL, d);
      n_cmp++;
      if (d !== {28'd0, 1'b1, 2'b00, en}) begin
        n_err++;
        $display("FAIL oneshot_ctrl k=%0d got=%h exp=%h", k, d, {28'd0, 1'b1, 2'b00, en});
      end
    end
    wr(A_PRESET, 32'd5);
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_irq_clear got=%b exp=0", IRQ);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    bit exp_irq;
    logic [31:0] exp_ctrl;
    do_reset();
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_irq  = HAS_AUTO ? (k >= 5 && ((k - 5) % 6) == 0) : (k >= 5);
      exp_ctrl = HAS_AUTO ? 32'hB : ((k >= 6) ? 32'h8 : 32'h9);
      n_cmp++;
      if (IRQ !== exp_irq) begin
        n_err++;
        $display("FAIL auto_irq k=%0d got=%b exp=%b", k, IRQ, exp_irq);
      end
      rd(A_CTRL, d);
      n_cmp++;
      if (d !== exp_ctrl) begin
        n_err++;
        $display("FAIL auto_ctrl k=%0d got=%h exp=%h", k, d, exp_ctrl);
      end
    end
  endtask

  task automatic test_random_runs();
    logic [31:0] d;
    logic [31:0] exp_ctrl;
    int n;
    int eff;
    int kmax;
    int c;
    logic [1:0] mode;
    bit im;
    bit autom;
    bit f;
    bit en;
    for (int it = 0; it < 8; it++) begin
      n     = (it == 0) ? 0 : (it == 1) ? 1 : int'($urandom_range(2, 9));
      mode  = 2'($urandom_range(0, 3));
      im    = 1'($urandom_range(0, 1));
      autom = HAS_AUTO && (mode == 2'd1);
      eff   = (n < 1) ? 1 : n;
      kmax  = eff + 2 + 2 * (eff + 3) + 1;
      do_reset();
      wr(A_PRESET, 32'(n));
      wr(A_CTRL, {28'd0, im, mode, 1'b1});
      for (int k = 1; k <= kmax; k++) begin
        tick();
        ref_point(k, n, autom, c, f, en);
        rd(A_COUNT, d);
        n_cmp++;
        if (d !== 32'(c)) begin
          n_err++;
          $display("FAIL rand_count it=%0d n=%0d mode=%0d k=%0d got=%0d exp=%0d", it, n, mode, k, d, c);
        end
        n_cmp++;
        if (IRQ !== (im & f)) begin
          n_err++;
          $display("FAIL rand_irq it=%0d n=%0d mode=%0d k=%0d got=%b exp=%b", it, n, mode, k, IRQ, im & f);
        end
        exp_ctrl = {28'd0, im, (HAS_AUTO ? mode : 2'b00), en};
        rd(A_CTRL, d);
        n_cmp++;
        if (d !== exp_ctrl) begin
          n_err++;
          $display("FAIL rand_ctrl it=%0d k=%0d got=%h exp=%h", it, k, d, exp_ctrl);
        end
      end
    end
  endtask

  task automatic test_stop_restart();
    logic [31:0] d;
    logic [31:0] p1;
    logic [31:0] p2;
    int guard;
    p1 = 32'($urandom_range(12, 20));
    p2 = 32'($urandom_range(30, 40));
    do_reset();
    wr(A_PRESET, p1);
    wr(A_CTRL, 32'h9);
    tick();
    tick();
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== p1) begin
      n_err++;
      $display("FAIL stop_load got=%0d exp=%0d", d, p1);
    end
    wr(A_PRESET, p2);
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== p1 - 32'd1) begin
      n_err++;
      $display("FAIL stop_preset_midcount got=%0d exp=%0d", d, p1 - 32'd1);
    end
    guard = 0;
    while (d !== 32'd7 && guard < 40) begin
      tick();
      rd(A_COUNT, d);
      guard++;
    end
    n_cmp++;
    if (d !== 32'd7) begin
      n_err++;
      $display("FAIL stop_wait7 timeout got=%0d exp=7", d);
    end
    wr(A_CTRL, 32'h8);
    for (int i = 0; i < 3; i++) begin
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd6) begin
        n_err++;
        $display("FAIL stop_hold i=%0d got=%0d exp=6", i, d);
      end
      tick();
    end
    rd(A_CTRL, d);
    n_cmp++;
    if (d !== 32'h8) begin
      n_err++;
      $display("FAIL stop_ctrl got=%h exp=8", d);
    end
    wr(A_CTRL, 32'h9);
    tick();
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== 32'd6) begin
      n_err++;
      $display("FAIL restart_load_edge got=%0d exp=6", d);
    end
    tick();
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== p2) begin
      n_err++;
      $display("FAIL restart_reload got=%0d exp=%0d", d, p2);
    end
    tick();
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== p2 - 32'd1) begin
      n_err++;
      $display("FAIL restart_decrement got=%0d exp=%0d", d, p2 - 32'd1);
    end
  endtask

  task automatic test_ignored_and_mask();
    logic [31:0] d;
    do_reset();
    wr(A_PRESET, 32'd2);
    wr(A_COUNT, 32'hDEAD);
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL ign_count got=%h exp=0", d);
    end
    rd(A_RSVD, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL ign_rsvd got=%h exp=0", d);
    end
    rd(A_PRESET, d);
    n_cmp++;
    if (d !== 32'd2) begin
      n_err++;
      $display("FAIL ign_preset got=%h exp=2", d);
    end
    wr(A_CTRL, 32'hFFFF_FFF1);
    rd(A_CTRL, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL ign_ctrl_upper got=%h exp=1", d);
    end
    tick();
    tick();
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== 32'd2) begin
      n_err++;
      $display("FAIL mask_load got=%0d exp=2", d);
    end
    wr(A_COUNT, 32'hDEAD);
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== 32'd1) begin
      n_err++;
      $display("FAIL ign_count_running got=%0d exp=1", d);
    end
    for (int k = 4; k <= 9; k++) begin
      tick();
      rd(A_COUNT, d);
      n_cmp++;
      if (d !== 32'd0) begin
        n_err++;
        $display("FAIL mask_count k=%0d got=%0d exp=0", k, d);
      end
      n_cmp++;
      if (IRQ !== 1'b0) begin
        n_err++;
        $display("FAIL mask_irq k=%0d got=%b exp=0", k, IRQ);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] d;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], d);
      n_cmp++;
      if (d !== 32'd0) begin
        n_err++;
        $display("FAIL %s addr=%0h got=%h exp=0", tag, addrs[i], d);
      end
    end
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_err++;
      $display("FAIL %s irq got=%b exp=0", tag, IRQ);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    int guard;
    do_reset();
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    guard = 0;
    rd(A_COUNT, d);
    while (d !== 32'd4 && guard < 30) begin
      tick();
      rd(A_COUNT, d);
      guard++;
    end
    n_cmp++;
    if (d !== 32'd4) begin
      n_err++;
      $display("FAIL rst_cnt_wait timeout got=%0d exp=4", d);
    end
    do_reset();
    check_all_zero("rst_in_cnt");
    tick();
    rd(A_COUNT, d);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL rst_cnt_stays_idle got=%0d exp=0", d);
    end
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    guard = 0;
    while (IRQ !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (IRQ !== 1'b1) begin
      n_err++;
      $display("FAIL rst_int_wait timeout irq=%b exp=1", IRQ);
    end
    do_reset();
    check_all_zero("rst_in_int");
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 32'd0;
    Din   = 32'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_random_runs();
    test_stop_restart();
    test_ignored_and_mask();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
